// File: rtl/store_buffer.sv
// Circular store buffer: in-order allocation at issue, out-of-order execute
// writeback, youngest-first load bypass, and in-order drain of committed stores.
module store_buffer #(
  parameter int WORD_SIZE_P  = 16,
  parameter int SB_ENTRY     = 8,
  parameter int CDB_SB_WIDTH = $clog2(SB_ENTRY) + 2 * WORD_SIZE_P
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          alloc_v_i,
  output logic                          alloc_ready_o,
  output logic [$clog2(SB_ENTRY)-1:0]   alloc_sb_num_o,
  input  logic                          lsu_sb_v_i,
  input  logic [CDB_SB_WIDTH-1:0]       lsu_sb_i,
  input  logic [WORD_SIZE_P-1:0]        exe_ld_bypass_addr_i,
  input  logic [$clog2(SB_ENTRY)-1:0]   exe_ld_bypass_sb_num_i,
  output logic                          sb_ld_bypass_valid_o,
  output logic [WORD_SIZE_P-1:0]        sb_ld_bypass_value_o,
  input  logic                          commit_v_i,
  output logic                          mem_w_v_o,
  output logic [WORD_SIZE_P-1:0]        mem_w_addr_o,
  output logic [WORD_SIZE_P-1:0]        mem_w_data_o,
  input  logic                          mem_w_ready_i,
  input  logic                          mispredict_i,
  output logic                          empty_o
);

  localparam int SBW = $clog2(SB_ENTRY);

  logic [SB_ENTRY-1:0]    r_busy;
  logic [SB_ENTRY-1:0]    r_exec;
  logic [WORD_SIZE_P-1:0] r_addr [SB_ENTRY];
  logic [WORD_SIZE_P-1:0] r_data [SB_ENTRY];
  logic [SBW-1:0]         r_head;
  logic [SBW-1:0]         r_cmt;
  logic [SBW-1:0]         r_tail;
  logic [SBW:0]           r_count;
  logic [SBW:0]           r_ncmt;

  logic [SBW-1:0]         w_wb_num;
  logic [WORD_SIZE_P-1:0] w_wb_addr;
  logic [WORD_SIZE_P-1:0] w_wb_data;
  logic                   w_alloc;
  logic                   w_exec_wr;
  logic                   w_drain;
  logic [SBW-1:0]         w_cmt_nxt;
  logic [SBW:0]           w_ncmt_nxt;
  logic [SBW:0]           w_n_uncmt;
  logic [SB_ENTRY-1:0]    w_busy_nxt;
  logic [SB_ENTRY-1:0]    w_exec_nxt;
  logic [SBW-1:0]         w_byp_dist;
  logic [SBW-1:0]         w_byp_idx;

  assign w_wb_num  = lsu_sb_i[CDB_SB_WIDTH-1 -: SBW];
  assign w_wb_addr = lsu_sb_i[2*WORD_SIZE_P-1 -: WORD_SIZE_P];
  assign w_wb_data = lsu_sb_i[WORD_SIZE_P-1:0];

  assign alloc_ready_o  = r_count < (SBW+1)'(SB_ENTRY);
  assign alloc_sb_num_o = r_tail;
  assign empty_o        = r_count == '0;

  assign w_alloc   = alloc_v_i && alloc_ready_o && !mispredict_i;
  assign w_exec_wr = lsu_sb_v_i && !mispredict_i && r_busy[w_wb_num];

  // Only committed stores may leave; an explicit committed count avoids the
  // head==cmt ambiguity between "none committed" and "all committed".
  assign mem_w_v_o    = r_busy[r_head] && r_exec[r_head] && (r_ncmt != '0);
  assign mem_w_addr_o = mem_w_v_o ? r_addr[r_head] : '0;
  assign mem_w_data_o = mem_w_v_o ? r_data[r_head] : '0;
  assign w_drain      = mem_w_v_o && mem_w_ready_i;

  assign w_cmt_nxt  = r_cmt + SBW'(commit_v_i);
  assign w_ncmt_nxt = r_ncmt + (SBW+1)'(commit_v_i) - (SBW+1)'(w_drain);
  assign w_n_uncmt  = r_count - r_ncmt - (SBW+1)'(commit_v_i);

  // NOTE: always_comb assigns every output a default before any condition,
  // so no path leaves a value held and no latch is inferred.
  always_comb begin
    w_busy_nxt = r_busy;
    w_exec_nxt = r_exec;
    if (w_exec_wr) w_exec_nxt[w_wb_num] = 1'b1;
    if (w_alloc) begin
      w_busy_nxt[r_tail] = 1'b1;
      w_exec_nxt[r_tail] = 1'b0;
    end
    if (w_drain) begin
      w_busy_nxt[r_head] = 1'b0;
      w_exec_nxt[r_head] = 1'b0;
    end
    for (int i = 0; i < SB_ENTRY; i++) begin
      if (mispredict_i && ({1'b0, SBW'(SBW'(i) - w_cmt_nxt)} < w_n_uncmt)) begin
        w_busy_nxt[i] = 1'b0;
        w_exec_nxt[i] = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_head  <= '0;
      r_cmt   <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_ncmt  <= '0;
      r_busy  <= '0;
      r_exec  <= '0;
    end else begin
      r_head <= r_head + SBW'(w_drain);
      r_cmt  <= w_cmt_nxt;
      r_ncmt <= w_ncmt_nxt;
      r_busy <= w_busy_nxt;
      r_exec <= w_exec_nxt;
      if (mispredict_i) begin
        r_tail  <= w_cmt_nxt;
        r_count <= w_ncmt_nxt;
      end else begin
        r_tail  <= r_tail + SBW'(w_alloc);
        r_count <= r_count + (SBW+1)'(w_alloc) - (SBW+1)'(w_drain);
      end
    end
  end

  // NOTE: the address/data array is deliberately not reset; busy/exec gate
  // every use of it, so stale contents are never observable.
  always_ff @(posedge clk_i) begin
    if (w_exec_wr) begin
      r_addr[w_wb_num] <= w_wb_addr;
      r_data[w_wb_num] <= w_wb_data;
    end
  end

  // Youngest-first scan of [head, sb_num); the first executed match wins.
  assign w_byp_dist = exe_ld_bypass_sb_num_i - r_head;

  always_comb begin
    sb_ld_bypass_valid_o = 1'b0;
    sb_ld_bypass_value_o = '0;
    w_byp_idx            = '0;
    for (int k = 0; k < SB_ENTRY; k++) begin
      w_byp_idx = exe_ld_bypass_sb_num_i - SBW'(k + 1);
      if (!sb_ld_bypass_valid_o && (k < int'(w_byp_dist)) &&
          r_busy[w_byp_idx] && r_exec[w_byp_idx] &&
          (r_addr[w_byp_idx] == exe_ld_bypass_addr_i)) begin
        sb_ld_bypass_valid_o = 1'b1;
        sb_ld_bypass_value_o = r_data[w_byp_idx];
      end
    end
  end

  a_commit_contract: assert property (@(posedge clk_i) disable iff (reset_i)
    commit_v_i |-> (r_busy[r_cmt] && r_exec[r_cmt] && (r_count != r_ncmt)));

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed stimulus with a drain
// scoreboard filled at commit and emptied as the memory accepts stores.
module tb_store_buffer;
  localparam int W   = 16;
  localparam int N   = 8;
  localparam int SBW = 3;

  logic           clk_i = 1'b0;
  logic           reset_i = 1'b1;
  logic           alloc_v_i = 1'b0;
  logic           alloc_ready_o;
  logic [SBW-1:0] alloc_sb_num_o;
  logic           lsu_sb_v_i = 1'b0;
  logic [SBW+2*W-1:0] lsu_sb_i = '0;
  logic [W-1:0]   exe_ld_bypass_addr_i = '0;
  logic [SBW-1:0] exe_ld_bypass_sb_num_i = '0;
  logic           sb_ld_bypass_valid_o;
  logic [W-1:0]   sb_ld_bypass_value_o;
  logic           commit_v_i = 1'b0;
  logic           mem_w_v_o;
  logic [W-1:0]   mem_w_addr_o;
  logic [W-1:0]   mem_w_data_o;
  logic           mem_w_ready_i = 1'b0;
  logic           mispredict_i = 1'b0;
  logic           empty_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [W-1:0] m_addr [N];
  logic [W-1:0] m_data [N];
  logic [SBW-1:0] m_cmt = '0;

  always #5 clk_i = ~clk_i;

  store_buffer #(.WORD_SIZE_P(W), .SB_ENTRY(N)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .alloc_v_i(alloc_v_i), .alloc_ready_o(alloc_ready_o), .alloc_sb_num_o(alloc_sb_num_o),
    .lsu_sb_v_i(lsu_sb_v_i), .lsu_sb_i(lsu_sb_i),
    .exe_ld_bypass_addr_i(exe_ld_bypass_addr_i), .exe_ld_bypass_sb_num_i(exe_ld_bypass_sb_num_i),
    .sb_ld_bypass_valid_o(sb_ld_bypass_valid_o), .sb_ld_bypass_value_o(sb_ld_bypass_value_o),
    .commit_v_i(commit_v_i), .mem_w_v_o(mem_w_v_o), .mem_w_addr_o(mem_w_addr_o),
    .mem_w_data_o(mem_w_data_o), .mem_w_ready_i(mem_w_ready_i),
    .mispredict_i(mispredict_i), .empty_o(empty_o)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    alloc_v_i    = 1'b0;
    lsu_sb_v_i   = 1'b0;
    commit_v_i   = 1'b0;
    mispredict_i = 1'b0;
  endtask

  task automatic alloc();
    tick();
    alloc_v_i = 1'b1;
  endtask

  task automatic wr(input logic [SBW-1:0] num, input logic [W-1:0] addr, input logic [W-1:0] data);
    tick();
    lsu_sb_v_i   = 1'b1;
    lsu_sb_i     = {num, addr, data};
    m_addr[num]  = addr;
    m_data[num]  = data;
  endtask

  task automatic commit();
    tick();
    commit_v_i = 1'b1;
    exp_q.push_back({m_addr[m_cmt], m_data[m_cmt]});
    m_cmt++;
  endtask

  task automatic query(input logic [W-1:0] addr, input logic [SBW-1:0] num);
    exe_ld_bypass_addr_i   = addr;
    exe_ld_bypass_sb_num_i = num;
    #1;
  endtask

  task automatic do_reset();
    tick();
    reset_i       = 1'b1;
    mem_w_ready_i = 1'b0;
    tick();
    reset_i = 1'b0;
    exp_q.delete();
    m_cmt = '0;
    #1;
    check("rst_alloc_ready", alloc_ready_o, 1);
    check("rst_alloc_num", alloc_sb_num_o, 0);
    check("rst_empty", empty_o, 1);
    check("rst_mem_w_v", mem_w_v_o, 0);
    check("rst_mem_w_addr", mem_w_addr_o, 0);
    check("rst_mem_w_data", mem_w_data_o, 0);
    check("rst_byp_valid", sb_ld_bypass_valid_o, 0);
    check("rst_byp_value", sb_ld_bypass_value_o, 0);
  endtask

  // Drain monitor: every accepted store must match the oldest committed one.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk_i);
      #2;
      if (reset_i === 1'b0 && mem_w_v_o === 1'b1 && mem_w_ready_i === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("drain_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("drain_addr", {16'h0, mem_w_addr_o}, {16'h0, e[31:16]});
          check("drain_data", {16'h0, mem_w_data_o}, {16'h0, e[15:0]});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Fill all entries; the ninth request is ignored.
    for (int i = 0; i < N; i++) begin
      alloc();
      #1;
      check("fill_num", alloc_sb_num_o, i);
      check("fill_ready", alloc_ready_o, 1);
    end
    alloc();
    #1;
    check("full_ready", alloc_ready_o, 0);
    check("full_tail", alloc_sb_num_o, 0);
    tick();
    #1;
    check("full_tail_hold", alloc_sb_num_o, 0);
    check("full_not_empty", empty_o, 0);

    // Single store forwarding, visible only the cycle after writeback.
    do_reset();
    alloc();
    wr(0, 16'h0040, 16'hBEEF);
    query(16'h0040, 1);
    check("byp_same_cycle", sb_ld_bypass_valid_o, 0);
    tick();
    #1;
    check("byp_hit_v", sb_ld_bypass_valid_o, 1);
    check("byp_hit_val", sb_ld_bypass_value_o, 16'hBEEF);
    query(16'h0040, 0);
    check("byp_empty_v", sb_ld_bypass_valid_o, 0);
    check("byp_empty_val", sb_ld_bypass_value_o, 0);

    // Youngest older store wins.
    alloc();
    wr(1, 16'h0040, 16'h2222);
    wr(0, 16'h0040, 16'h1111);
    tick();
    query(16'h0040, 2);
    check("byp_young_val", sb_ld_bypass_value_o, 16'h2222);
    query(16'h0040, 1);
    check("byp_old_val", sb_ld_bypass_value_o, 16'h1111);
    query(16'h0042, 2);
    check("byp_miss_v", sb_ld_bypass_valid_o, 0);

    // Commit with mispredict in the same cycle: only entry 0 survives.
    do_reset();
    for (int i = 0; i < 3; i++) alloc();
    for (int i = 0; i < 3; i++) wr(SBW'(i), 16'h0100 + 16'(i), 16'hA000 + 16'(i));
    tick();
    #1;
    check("uncommitted_no_drain", mem_w_v_o, 0);
    tick();
    commit_v_i   = 1'b1;
    mispredict_i = 1'b1;
    exp_q.push_back({m_addr[m_cmt], m_data[m_cmt]});
    m_cmt++;
    tick();
    #1;
    check("mp_tail", alloc_sb_num_o, 1);
    check("mp_drain_v", mem_w_v_o, 1);
    check("mp_drain_addr", mem_w_addr_o, 16'h0100);
    check("mp_drain_data", mem_w_data_o, 16'hA000);
    query(16'h0101, 3);
    check("mp_flushed_skip", sb_ld_bypass_valid_o, 0);
    query(16'h0100, 1);
    check("mp_committed_byp", sb_ld_bypass_value_o, 16'hA000);
    tick();
    #1;
    check("mp_drain_held", mem_w_v_o, 1);
    tick();
    mem_w_ready_i = 1'b1;
    tick();
    mem_w_ready_i = 1'b0;
    #1;
    check("mp_empty", empty_o, 1);
    check("mp_drain_done", mem_w_v_o, 0);
    check("mp_queue_empty", exp_q.size(), 0);
    for (int i = 0; i < N; i++) begin
      alloc();
      #1;
      check("mp_refill_ready", alloc_ready_o, 1);
      check("mp_refill_num", alloc_sb_num_o, (1 + i) % N);
    end
    tick();
    #1;
    check("mp_refill_full", alloc_ready_o, 0);

    // Move head to 6, then exercise the scan across the index wrap.
    do_reset();
    for (int i = 0; i < 6; i++) alloc();
    for (int i = 0; i < 6; i++) wr(SBW'(i), 16'h0010 + 16'(i), 16'(i));
    for (int i = 0; i < 6; i++) commit();
    tick();
    mem_w_ready_i = 1'b1;
    repeat (7) tick();
    mem_w_ready_i = 1'b0;
    #1;
    check("wrap_empty", empty_o, 1);
    check("wrap_tail", alloc_sb_num_o, 6);
    check("wrap_queue_empty", exp_q.size(), 0);
    for (int i = 0; i < 3; i++) alloc();
    wr(6, 16'h0200, 16'h6666);
    wr(7, 16'h0300, 16'h7777);
    wr(0, 16'h0300, 16'h0A0A);
    tick();
    query(16'h0300, 1);
    check("wrap_hit_e0", sb_ld_bypass_value_o, 16'h0A0A);
    query(16'h0300, 0);
    check("wrap_hit_e7", sb_ld_bypass_value_o, 16'h7777);
    query(16'h0200, 1);
    check("wrap_hit_e6", sb_ld_bypass_value_o, 16'h6666);
    query(16'h0300, 6);
    check("wrap_range_empty", sb_ld_bypass_valid_o, 0);

    // Drain and allocate together; occupancy must stay level.
    for (int i = 0; i < 3; i++) commit();
    for (int i = 0; i < 3; i++) begin
      alloc();
      mem_w_ready_i = 1'b1;
      #1;
      check("both_num", alloc_sb_num_o, 1 + i);
    end
    tick();
    mem_w_ready_i = 1'b0;
    #1;
    check("both_tail", alloc_sb_num_o, 4);
    check("both_not_empty", empty_o, 0);
    for (int i = 0; i < 5; i++) begin
      alloc();
      #1;
      check("both_fill_ready", alloc_ready_o, 1);
      check("both_fill_num", alloc_sb_num_o, (4 + i) % N);
    end
    tick();
    #1;
    check("both_full", alloc_ready_o, 0);
    check("both_full_tail", alloc_sb_num_o, 1);

    // Full with a committed store waiting, then reset.
    wr(1, 16'h0400, 16'h4444);
    commit();
    tick();
    #1;
    check("pend_drain_v", mem_w_v_o, 1);
    check("pend_drain_addr", mem_w_addr_o, 16'h0400);
    do_reset();

    tick();
    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
